// File: rtl/nibble_packer.sv
// Packs a valid/ready stream of 4-bit values into MSB-first words of NIBBLES nibbles.
// A word may close early on in_last, with the unused low slots filled by PAD.
module nibble_packer #(
    parameter int          NIBBLES = 8,
    parameter logic [3:0]  PAD     = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_word,
    output logic [$clog2(NIBBLES+1)-1:0] out_count
);

    localparam int WORD_W = 4 * NIBBLES;
    localparam int CNT_W  = $clog2(NIBBLES);
    localparam int OC_W   = $clog2(NIBBLES + 1);

    typedef enum logic {FILL, WAIT} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   asm_word;
    logic [WORD_W-1:0]   merged;
    logic                accept;
    logic                complete;
    logic                hold_free;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && (state == FILL);
    assign complete  = in_last || (cnt == CNT_W'(NIBBLES - 1));
    assign hold_free = !out_valid || out_ready;

    // Assembly word with the incoming nibble placed at slot cnt; on an early
    // close every later slot is overwritten with PAD.
    always_comb begin
        merged = asm_word;
        for (int i = 0; i < NIBBLES; i++) begin
            if (i == int'(cnt))
                merged[WORD_W-1-4*i -: 4] = in_data;
            else if (i > int'(cnt) && in_last)
                merged[WORD_W-1-4*i -: 4] = PAD;
        end
    end

    // In WAIT, cnt keeps the slot index of the closing nibble so the held
    // word's count is still available when it moves to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            asm_word  <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_count <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        asm_word <= merged;
                        if (complete) begin
                            if (hold_free) begin
                                out_valid <= 1'b1;
                                out_word  <= merged;
                                out_count <= OC_W'(cnt) + OC_W'(1);
                                cnt       <= '0;
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (hold_free) begin
                        out_valid <= 1'b1;
                        out_word  <= asm_word;
                        out_count <= OC_W'(cnt) + OC_W'(1);
                        cnt       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: inputs change and outputs are checked on the falling edge.
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [3:0]  out_count;

    int errors = 0;
    int checks = 0;

    nibble_packer #(.NIBBLES(8), .PAD(4'hF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one rising edge; returns on the following falling edge.
    task automatic step(input logic v, input logic [3:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] w, input logic [3:0] c);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_word"}, out_word, w);
        chk({tag, "_count"}, {28'd0, out_count}, {28'd0, c});
    endtask

    logic [3:0] seq_a [16];
    logic [3:0] nib;
    int         gap;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 4'h0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b0, 32'h0, 4'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Full word with consumer always ready
        step(1, 4'h8, 0, 1); step(1, 4'h9, 0, 1); step(1, 4'hA, 0, 1); step(1, 4'hB, 0, 1);
        step(1, 4'hC, 0, 1); step(1, 4'hB, 0, 1); step(1, 4'hE, 0, 1);
        chk("full_pre_valid", {31'd0, out_valid}, 32'd0);
        step(1, 4'hF, 0, 1);
        chk_out("full", 1'b1, 32'h89ABCBEF, 4'd8);
        step(0, 4'h0, 0, 1);
        chk("full_one_cycle", {31'd0, out_valid}, 32'd0);

        // Early closes
        step(1, 4'h3, 0, 1); step(1, 4'h1, 0, 1); step(1, 4'h5, 1, 1);
        chk_out("early3", 1'b1, 32'h315FFFFF, 4'd3);
        step(0, 4'h0, 0, 1);
        chk("early3_drop", {31'd0, out_valid}, 32'd0);
        step(1, 4'h7, 1, 1);
        chk_out("early1", 1'b1, 32'h7FFFFFFF, 4'd1);
        step(0, 4'h0, 0, 1);

        // Backpressure: 16 nibbles with consumer stalled
        for (int i = 0; i < 16; i++) seq_a[i] = 4'(i);
        for (int i = 0; i < 8; i++) step(1, seq_a[i], 0, 0);
        chk_out("bp_first", 1'b1, 32'h01234567, 4'd8);
        chk("bp_ready_fill", {31'd0, in_ready}, 32'd1);
        for (int i = 8; i < 16; i++) step(1, seq_a[i], 0, 0);
        chk_out("bp_hold", 1'b1, 32'h01234567, 4'd8);
        chk("bp_ready_wait", {31'd0, in_ready}, 32'd0);
        step(0, 4'h0, 0, 0);
        chk_out("bp_stable", 1'b1, 32'h01234567, 4'd8);
        chk("bp_still_wait", {31'd0, in_ready}, 32'd0);
        step(0, 4'h0, 0, 1);
        chk_out("bp_second", 1'b1, 32'h89ABCDEF, 4'd8);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step(0, 4'h0, 0, 1);
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // Completion in the same cycle as an output handshake
        for (int i = 0; i < 8; i++) step(1, 4'(i + 1), 0, 0);
        chk_out("simul_a", 1'b1, 32'h12345678, 4'd8);
        for (int i = 0; i < 7; i++) step(1, 4'(15 - i), 0, 0);
        chk_out("simul_a_held", 1'b1, 32'h12345678, 4'd8);
        chk("simul_ready", {31'd0, in_ready}, 32'd1);
        step(1, 4'h8, 0, 1);
        chk_out("simul_b", 1'b1, 32'hFEDCBA98, 4'd8);
        step(0, 4'h0, 0, 1);
        chk("simul_no_dup", {31'd0, out_valid}, 32'd0);

        // Idle gaps between nibbles; idle cycles carry junk that must be ignored
        for (int i = 0; i < 16; i++) begin
            gap = i % 3;
            for (int g = 0; g < gap; g++) begin
                step(0, 4'h5, 1, 1);
                chk("gap_idle", {31'd0, out_valid}, 32'd0);
            end
            nib = (i < 8) ? 4'(2 * i + 2) : 4'(2 * (i - 8) + 1);
            step(1, nib, 0, 1);
            if (i == 7)
                chk_out("gap_word_c", 1'b1, 32'h2468ACE0, 4'd8);
            else if (i == 15)
                chk_out("gap_word_d", 1'b1, 32'h13579BDF, 4'd8);
            else
                chk("gap_active", {31'd0, out_valid}, 32'd0);
        end
        step(0, 4'h0, 0, 1);

        // Reset mid-word
        for (int i = 0; i < 5; i++) step(1, 4'(i), 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 32'h0, 4'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 4'hA, 0, 0); step(1, 4'hB, 0, 0); step(1, 4'hC, 0, 0); step(1, 4'hD, 0, 0);
        step(1, 4'hE, 0, 0); step(1, 4'hF, 0, 0); step(1, 4'h0, 0, 0); step(1, 4'h1, 0, 0);
        chk_out("rst_mid_next", 1'b1, 32'hABCDEF01, 4'd8);

        // Reset while waiting
        for (int i = 0; i < 8; i++) step(1, 4'(i), 0, 0);
        chk("pre_rst_wait", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_out("rst_wait", 1'b0, 32'h0, 4'd0);
        chk("rst_wait_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) step(1, 4'(i + 5), 0, 1);
        chk_out("rst_wait_next", 1'b1, 32'h56789ABC, 4'd8);
        step(0, 4'h0, 0, 1);
        chk("final_drain", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Upstream feeder for the combinational `sort` stage. It accepts a serial stream of 4-bit values over a valid/ready handshake and packs eight of them into one 32-bit word, first-received nibble in bits [31:28]. Each completed word is presented on a registered output, with its own valid/ready handshake, for direct connection to `sort`'s `A` input. A stream can end early with `in_last`; the unused low nibbles are then filled with a pad value.

## Interface

Parameters:
- `NIBBLES`, 8: nibbles per word. The output width is 4*`NIBBLES`. 8 matches the 32-bit `sort` input.
- `PAD`, 4'hF: value written into the unfilled nibble slots of a word closed by `in_last`.

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: the block accepts a nibble this cycle.
- `in_data`  in  4: nibble value.
- `in_last`  in  1: the accepted nibble ends the current word; sampled only when `in_valid && in_ready`.
- `out_valid`  out  1: the holding register contains a word.
- `out_ready`  in  1: the consumer takes the word this cycle.
- `out_word`  out  32: packed word (4*`NIBBLES`), MSB-first.
- `out_count`  out  4: number of real (non-pad) nibbles in `out_word`, 1..8.

## Operation

- Datapath:
  - Assembly register `asm` (32 bits) with a fill counter `cnt` (0..7).
  - Holding register with `out_valid`, `out_word` and `out_count`.
- Accept rule: a nibble is accepted when `in_valid && in_ready`.
  - The nibble is written to slot `cnt`, at bits [31-4*cnt -: 4].
  - `cnt` then increments.
- A word is complete when the accepted nibble fills slot 7, or when `in_last` is 1 on the accepted nibble.
  - For an early close, slots cnt+1..7 are written with `PAD`.
  - `out_count` = (slot index of the closing nibble) + 1.
- The holding register is free when `out_valid == 0`, or when `out_valid && out_ready` in the same cycle.
- FSM, two states:
  - FILL (reset state): `in_ready` = 1.
    - Word completes and holding is free: transfer the word to holding, clear `cnt`, stay in FILL.
    - Word completes and holding is not free: keep the word in `asm` and go to WAIT.
  - WAIT: `in_ready` = 0.
    - When holding becomes free, transfer `asm` to holding, clear `cnt`, go to FILL.
- `in_ready` is a decode of the FSM state only. There is no combinational path from `out_ready` to `in_ready`.
- Output behaviour:
  - `out_valid` falls only on `out_valid && out_ready` with no transfer in that same cycle.
  - While `out_valid && !out_ready`, `out_word` and `out_count` are held stable.
- `in_data` and `in_last` are ignored when no handshake occurs.
- An empty word is never produced: a word closed by `in_last` always carries at least 1 nibble.

## Timing

- Reset (asynchronous, while `rst_n` = 0):
  - Registers: state = FILL, `cnt` = 0, `asm` = 0, `out_valid` = 0, `out_word` = 0, `out_count` = 0.
  - Output `in_ready` reads 1 (decoded from FILL).
- Latency: `out_valid` rises on the clock edge that accepts the completing nibble, so the word is visible the cycle after that handshake.
- Throughput: 1 nibble per cycle sustained. With `out_ready` held at 1 this gives 1 word per 8 cycles and no bubbles.
- Back-to-back transfer: completion in FILL in the same cycle as an output handshake replaces the holding contents. `out_valid` stays 1 and the new word appears on the next edge.
- Stall: `in_ready` falls on the edge that enters WAIT. It rises on the edge after the output handshake that frees the holding register, and on that same edge the waiting word is loaded.
- Reset asserted mid-word or in WAIT discards partial and held data with no output. The first word after reset starts at slot 0.

## Test plan

- Full word: with `out_ready` = 1, send 8,9,A,B,C,B,E,F on consecutive cycles with no `in_last`. Required: one cycle later, `out_word` = 32'h89ABCBEF, `out_count` = 8, `out_valid` high for exactly 1 cycle.
- Early close: send 3,1,5 with `in_last` on the 5. Required: `out_word` = 32'h315FFFFF, `out_count` = 3. A single nibble 7 with `in_last` gives 32'h7FFFFFFF, `out_count` = 1.
- Backpressure: with `out_ready` = 0, send 16 nibbles 0..F.
  - Holding = 32'h01234567 and stable.
  - `in_ready` drops after the 16th nibble is accepted.
  - Raise `out_ready`: the outputs are 32'h01234567, then 32'h89ABCDEF on the next cycle. `in_ready` returns to 1 one cycle after the first handshake.
- Simultaneous events: complete a word in the same cycle that the previous word handshakes out. Required: `out_valid` stays 1, the new word appears on the next edge, and no word is lost or duplicated.
- Idle gaps: `in_valid` toggling randomly across two words. Required: nibble order is preserved and there is no output while `in_valid` = 0.
- Reset mid-operation: pulse `rst_n` low after 5 nibbles, and again while in WAIT. Required: all outputs return to their reset values immediately, `in_ready` = 1, and the next 8 nibbles produce a correctly aligned word.
